// File: rtl/panxi_sram_ctrl.sv
// Valid/ready command-to-SRAM controller with an in-order response FIFO.
// Optional address checking is enabled by defining PANXI_SRAM_CTRL_ERR_EN.
module panxi_sram_ctrl #(
    parameter int          DATA_WIDTH = 32,
    parameter int          ADDR_WIDTH = 10,
    parameter int          RSP_DEPTH  = 2,
    parameter logic [31:0] BASE_ADDR  = 32'h0000_0000
) (
    input  logic                    ACLK,
    input  logic                    ARESETN,
    input  logic                    cmd_valid,
    output logic                    cmd_ready,
    input  logic                    cmd_read,
    input  logic [31:0]             cmd_addr,
    input  logic [DATA_WIDTH-1:0]   cmd_wdata,
    input  logic [DATA_WIDTH/8-1:0] cmd_wmask,
    output logic                    rsp_valid,
    input  logic                    rsp_ready,
    output logic [DATA_WIDTH-1:0]   rsp_rdata,
    output logic                    rsp_err,
    output logic                    sram_cen,
    output logic [ADDR_WIDTH-1:0]   sram_addr,
    output logic [DATA_WIDTH-1:0]   sram_wdata,
    output logic                    sram_gwen,
    output logic [DATA_WIDTH-1:0]   sram_wen,
    input  logic [DATA_WIDTH-1:0]   sram_rdata
);

    localparam int NB = DATA_WIDTH / 8;
    localparam int PW = $clog2(RSP_DEPTH);
    localparam int CW = $clog2(RSP_DEPTH + 1);
    localparam int OW = CW + 1;

    logic                  accept;
    logic                  addr_err;
    logic                  access;
    logic                  is_write;
    logic [DATA_WIDTH-1:0] wmask_bits;

    genvar gi;
    generate
        for (gi = 0; gi < NB; gi++) begin : g_mask
            assign wmask_bits[gi*8 +: 8] = {8{cmd_wmask[gi]}};
        end
    endgenerate

`ifdef PANXI_SRAM_CTRL_ERR_EN
    assign addr_err = (cmd_addr[31:ADDR_WIDTH+2] != BASE_ADDR[31:ADDR_WIDTH+2])
                   || (cmd_addr[1:0] != 2'b00);
`else
    // Upper and sub-word address bits alias; nothing can flag an error.
    logic unused_addr_bits;
    assign addr_err         = 1'b0;
    assign unused_addr_bits = ^{cmd_addr[31:ADDR_WIDTH+2], cmd_addr[1:0], BASE_ADDR};
`endif

    // An accepted write with no strobes, or an erroring command, skips the SRAM
    // but still earns a response.
    assign accept   = cmd_valid & cmd_ready;
    assign access   = accept & ~addr_err & (cmd_read | (|cmd_wmask));
    assign is_write = access & ~cmd_read;

    assign sram_cen   = ~access;
    assign sram_gwen  = ~is_write;
    assign sram_wen   = is_write ? ~wmask_bits : {DATA_WIDTH{1'b1}};
    assign sram_addr  = cmd_addr[ADDR_WIDTH+1:2];
    assign sram_wdata = cmd_wdata;

    logic inflight_vld_q, inflight_vld_d;
    logic inflight_rd_q,  inflight_rd_d;
    logic inflight_err_q, inflight_err_d;

    always_comb begin
        inflight_vld_d = accept;
        inflight_rd_d  = cmd_read & ~addr_err;
        inflight_err_d = addr_err;
    end

    logic [DATA_WIDTH-1:0] fifo_data_q [RSP_DEPTH];
    logic [DATA_WIDTH-1:0] fifo_data_d [RSP_DEPTH];
    logic [RSP_DEPTH-1:0]  fifo_err_q,  fifo_err_d;
    logic [PW-1:0]         wr_ptr_q,    wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q,    rd_ptr_d;
    logic [CW-1:0]         count_q,     count_d;
    logic                  push;
    logic                  pop;
    logic [DATA_WIDTH-1:0] push_data;
    logic [OW-1:0]         occupancy;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(RSP_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign push      = inflight_vld_q;
    assign pop       = rsp_valid & rsp_ready;
    assign push_data = inflight_rd_q ? sram_rdata : '0;

    // Credit counts the in-flight slot and the slot freed by this cycle's pop,
    // so a full FIFO drained every cycle still accepts one command per cycle.
    assign occupancy = OW'(count_q) + OW'(inflight_vld_q) - OW'(pop);
    assign cmd_ready = occupancy < OW'(RSP_DEPTH);

    assign rsp_valid = (count_q != '0);
    assign rsp_rdata = rsp_valid ? fifo_data_q[rd_ptr_q] : '0;
    assign rsp_err   = rsp_valid & fifo_err_q[rd_ptr_q];

    always_comb begin
        fifo_data_d = fifo_data_q;
        fifo_err_d  = fifo_err_q;
        wr_ptr_d    = wr_ptr_q;
        rd_ptr_d    = rd_ptr_q;
        count_d     = count_q;
        if (push) begin
            fifo_data_d[wr_ptr_q] = push_data;
            fifo_err_d[wr_ptr_q]  = inflight_err_q;
            wr_ptr_d              = ptr_inc(wr_ptr_q);
        end
        if (pop) begin
            rd_ptr_d = ptr_inc(rd_ptr_q);
        end
        case ({push, pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge ACLK or negedge ARESETN) begin
        if (!ARESETN) begin
            inflight_vld_q <= 1'b0;
            inflight_rd_q  <= 1'b0;
            inflight_err_q <= 1'b0;
            fifo_err_q     <= '0;
            wr_ptr_q       <= '0;
            rd_ptr_q       <= '0;
            count_q        <= '0;
        end else begin
            inflight_vld_q <= inflight_vld_d;
            inflight_rd_q  <= inflight_rd_d;
            inflight_err_q <= inflight_err_d;
            fifo_err_q     <= fifo_err_d;
            wr_ptr_q       <= wr_ptr_d;
            rd_ptr_q       <= rd_ptr_d;
            count_q        <= count_d;
        end
    end

    // Payload storage needs no reset: it is only visible behind rsp_valid.
    always_ff @(posedge ACLK) begin
        fifo_data_q <= fifo_data_d;
    end

endmodule

// File: tb/tb_panxi_sram_ctrl.sv
// Directed testbench for panxi_sram_ctrl with a behavioural 1024x32 SRAM.
// Checks strobes, masking, latency, throughput, backpressure, errors and reset.
module tb_panxi_sram_ctrl;

    logic        clk = 1'b0;
    logic        ARESETN;
    logic        cmd_valid, cmd_ready, cmd_read;
    logic [31:0] cmd_addr, cmd_wdata;
    logic [3:0]  cmd_wmask;
    logic        rsp_valid, rsp_ready, rsp_err;
    logic [31:0] rsp_rdata;
    logic        sram_cen, sram_gwen;
    logic [9:0]  sram_addr;
    logic [31:0] sram_wdata, sram_wen, sram_rdata;

    int n_cmp = 0;
    int n_err = 0;

    logic [31:0] smem [1024];

    always #5 clk = ~clk;

    panxi_sram_ctrl dut (
        .ACLK(clk), .ARESETN(ARESETN),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_read(cmd_read),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata), .cmd_wmask(cmd_wmask),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .sram_cen(sram_cen), .sram_addr(sram_addr), .sram_wdata(sram_wdata),
        .sram_gwen(sram_gwen), .sram_wen(sram_wen), .sram_rdata(sram_rdata)
    );

    // SRAM model: bit-masked write, read data one cycle after the access.
    always @(posedge clk) begin
        if (!sram_cen) begin
            if (!sram_gwen)
                smem[sram_addr] = (smem[sram_addr] & sram_wen) | (sram_wdata & ~sram_wen);
            else
                sram_rdata <= smem[sram_addr];
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    task automatic do_cmd(input string name, input logic rd, input logic [31:0] addr,
                          input logic [31:0] wdata, input logic [3:0] mask,
                          input logic exp_cen, input logic [9:0] exp_addr,
                          input logic [31:0] exp_wen, input logic [31:0] exp_rdata,
                          input logic exp_err);
        cmd_valid = 1'b1; cmd_read = rd; cmd_addr = addr; cmd_wdata = wdata; cmd_wmask = mask;
        #3;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL %s_ready: got %b expected 1", name, cmd_ready); end
        n_cmp++; if (sram_cen !== exp_cen) begin n_err++; $display("FAIL %s_cen: got %b expected %b", name, sram_cen, exp_cen); end
        if (!exp_cen) begin
            n_cmp++; if (sram_gwen !== rd) begin n_err++; $display("FAIL %s_gwen: got %b expected %b", name, sram_gwen, rd); end
            n_cmp++; if (sram_wen !== exp_wen) begin n_err++; $display("FAIL %s_wen: got %h expected %h", name, sram_wen, exp_wen); end
            n_cmp++; if (sram_addr !== exp_addr) begin n_err++; $display("FAIL %s_addr: got %h expected %h", name, sram_addr, exp_addr); end
            if (!rd) begin
                n_cmp++; if (sram_wdata !== wdata) begin n_err++; $display("FAIL %s_wdata: got %h expected %h", name, sram_wdata, wdata); end
            end
        end
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        #3;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL %s_early_rsp: got %b expected 0", name, rsp_valid); end
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b1) begin n_err++; $display("FAIL %s_rsp_valid: got %b expected 1", name, rsp_valid); end
        n_cmp++; if (rsp_rdata !== exp_rdata) begin n_err++; $display("FAIL %s_rdata: got %h expected %h", name, rsp_rdata, exp_rdata); end
        n_cmp++; if (rsp_err !== exp_err) begin n_err++; $display("FAIL %s_err: got %b expected %b", name, rsp_err, exp_err); end
        $display("txn %s rd=%0b addr=%h rsp_rdata=%h rsp_err=%0b", name, rd, addr, rsp_rdata, rsp_err);
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL %s_drain: got %b expected 0", name, rsp_valid); end
    endtask

    task automatic test_reset();
        ARESETN = 1'b0; cmd_valid = 1'b0; cmd_read = 1'b0; cmd_addr = '0;
        cmd_wdata = '0; cmd_wmask = '0; rsp_ready = 1'b0;
        #12;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL rst_cmd_ready: got %b expected 1", cmd_ready); end
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL rst_rsp_valid: got %b expected 0", rsp_valid); end
        n_cmp++; if (rsp_rdata !== 32'h0) begin n_err++; $display("FAIL rst_rsp_rdata: got %h expected 0", rsp_rdata); end
        n_cmp++; if (rsp_err !== 1'b0) begin n_err++; $display("FAIL rst_rsp_err: got %b expected 0", rsp_err); end
        n_cmp++; if ({sram_cen, sram_gwen} !== 2'b11) begin n_err++; $display("FAIL rst_cen_gwen: got %b expected 11", {sram_cen, sram_gwen}); end
        n_cmp++; if (sram_wen !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL rst_wen: got %h expected ffffffff", sram_wen); end
        $display("txn reset");
        ARESETN = 1'b1;
        @(posedge clk); #1;
    endtask

    task automatic test_write_read();
        do_cmd("write_full", 1'b0, 32'h10, 32'hDEAD_BEEF, 4'hF, 1'b0, 10'd4, 32'h0000_0000, 32'h0, 1'b0);
        do_cmd("read_back", 1'b1, 32'h10, 32'h0, 4'h0, 1'b0, 10'd4, 32'hFFFF_FFFF, 32'hDEAD_BEEF, 1'b0);
        do_cmd("write_mask", 1'b0, 32'h10, 32'h1122_3344, 4'b0101, 1'b0, 10'd4, 32'hFF00_FF00, 32'h0, 1'b0);
        do_cmd("read_mask", 1'b1, 32'h10, 32'h0, 4'h0, 1'b0, 10'd4, 32'hFFFF_FFFF, 32'hDE22_BE44, 1'b0);
        do_cmd("write_zero_mask", 1'b0, 32'h10, 32'hFFFF_FFFF, 4'h0, 1'b1, 10'd4, 32'hFFFF_FFFF, 32'h0, 1'b0);
        do_cmd("read_unchanged", 1'b1, 32'h10, 32'h0, 4'h0, 1'b0, 10'd4, 32'hFFFF_FFFF, 32'hDE22_BE44, 1'b0);
    endtask

    task automatic test_back_to_back();
        int got = 0;
        int first = -1;
        int last = -1;
        rsp_ready = 1'b1;
        fork
            begin
                for (int i = 0; i < 8; i++) begin
                    cmd_valid = 1'b1; cmd_read = 1'b1; cmd_addr = 32'h80 + 32'(4 * i); cmd_wmask = 4'h0;
                    #3;
                    n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL b2b_ready_%0d: got %b expected 1", i, cmd_ready); end
                    @(posedge clk); #1;
                end
                cmd_valid = 1'b0;
            end
            begin
                for (int c = 0; c < 14; c++) begin
                    @(negedge clk);
                    if (rsp_valid) begin
                        n_cmp++;
                        if (rsp_rdata !== (32'hA500_0000 + 32'(got))) begin
                            n_err++; $display("FAIL b2b_data_%0d: got %h expected %h", got, rsp_rdata, 32'hA500_0000 + 32'(got));
                        end
                        $display("txn b2b_rsp idx=%0d rsp_rdata=%h", got, rsp_rdata);
                        if (got == 0) first = c;
                        last = c;
                        got++;
                    end
                end
            end
        join
        @(posedge clk); #1;
        rsp_ready = 1'b0;
        n_cmp++; if (got !== 8) begin n_err++; $display("FAIL b2b_count: got %0d expected 8", got); end
        n_cmp++; if (last - first !== 7) begin n_err++; $display("FAIL b2b_rate: got span %0d expected 7", last - first); end
    endtask

    task automatic test_backpressure();
        int idx = 1;
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_read = 1'b1; cmd_wmask = 4'h0;
        cmd_addr = 32'h80; #3;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL bp_acc0: got %b expected 1", cmd_ready); end
        @(posedge clk); #1;
        cmd_addr = 32'h84; #3;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL bp_acc1: got %b expected 1", cmd_ready); end
        @(posedge clk); #1;
        cmd_addr = 32'h88;
        for (int c = 0; c < 3; c++) begin
            #3;
            n_cmp++; if (cmd_ready !== 1'b0) begin n_err++; $display("FAIL bp_stall_ready_%0d: got %b expected 0", c, cmd_ready); end
            n_cmp++; if (sram_cen !== 1'b1) begin n_err++; $display("FAIL bp_stall_cen_%0d: got %b expected 1", c, sram_cen); end
            n_cmp++; if (rsp_rdata !== 32'hA500_0000 && c > 0) begin n_err++; $display("FAIL bp_hold_%0d: got %h expected a5000000", c, rsp_rdata); end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b1; #3;
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL bp_resume_ready: got %b expected 1", cmd_ready); end
        n_cmp++; if (sram_cen !== 1'b0) begin n_err++; $display("FAIL bp_resume_cen: got %b expected 0", sram_cen); end
        n_cmp++; if (rsp_rdata !== 32'hA500_0000) begin n_err++; $display("FAIL bp_rsp0: got %h expected a5000000", rsp_rdata); end
        $display("txn bp_rsp idx=0 rsp_rdata=%h", rsp_rdata);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        for (int c = 0; c < 6; c++) begin
            #3;
            if (rsp_valid) begin
                n_cmp++;
                if (rsp_rdata !== (32'hA500_0000 + 32'(idx))) begin
                    n_err++; $display("FAIL bp_rsp%0d: got %h expected %h", idx, rsp_rdata, 32'hA500_0000 + 32'(idx));
                end
                $display("txn bp_rsp idx=%0d rsp_rdata=%h", idx, rsp_rdata);
                idx++;
            end
            @(posedge clk); #1;
        end
        rsp_ready = 1'b0;
        n_cmp++; if (idx !== 3) begin n_err++; $display("FAIL bp_count: got %0d expected 3", idx); end
    endtask

    task automatic test_addr_err();
`ifdef PANXI_SRAM_CTRL_ERR_EN
        do_cmd("read_out_of_range", 1'b1, 32'h0001_0000, 32'h0, 4'h0, 1'b1, 10'd0, 32'hFFFF_FFFF, 32'h0, 1'b1);
        do_cmd("read_misaligned", 1'b1, 32'h0000_0012, 32'h0, 4'h0, 1'b1, 10'd4, 32'hFFFF_FFFF, 32'h0, 1'b1);
`else
        do_cmd("read_alias", 1'b1, 32'h0001_0000, 32'h0, 4'h0, 1'b0, 10'd0, 32'hFFFF_FFFF, 32'h0BAD_F00D, 1'b0);
        do_cmd("read_alias_unaligned", 1'b1, 32'h0000_0012, 32'h0, 4'h0, 1'b0, 10'd4, 32'hFFFF_FFFF, 32'hDE22_BE44, 1'b0);
`endif
    endtask

    task automatic test_reset_mid();
        rsp_ready = 1'b0;
        cmd_valid = 1'b1; cmd_read = 1'b0; cmd_wmask = 4'hF;
        cmd_addr = 32'h200; cmd_wdata = 32'h0000_1111;
        @(posedge clk); #1;
        cmd_addr = 32'h204; cmd_wdata = 32'h0000_2222;
        @(posedge clk); #1;
        cmd_valid = 1'b0;
        @(posedge clk); #1;
        n_cmp++; if ({rsp_valid, cmd_ready} !== 2'b10) begin n_err++; $display("FAIL mid_full: got %b expected 10", {rsp_valid, cmd_ready}); end
        #1;
        ARESETN = 1'b0;
        #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_rst_valid: got %b expected 0", rsp_valid); end
        n_cmp++; if (cmd_ready !== 1'b1) begin n_err++; $display("FAIL mid_rst_ready: got %b expected 1", cmd_ready); end
        $display("txn reset_mid");
        #3;
        ARESETN = 1'b1;
        @(posedge clk); #1;
        n_cmp++; if (rsp_valid !== 1'b0) begin n_err++; $display("FAIL mid_after_rst: got %b expected 0", rsp_valid); end
        do_cmd("read_after_rst", 1'b1, 32'h204, 32'h0, 4'h0, 1'b0, 10'd129, 32'hFFFF_FFFF, 32'h0000_2222, 1'b0);
    endtask

    initial begin
        for (int i = 0; i < 1024; i++) smem[i] = 32'h0;
        smem[0] = 32'h0BAD_F00D;
        for (int i = 0; i < 8; i++) smem[32 + i] = 32'hA500_0000 + 32'(i);
        sram_rdata = '0;
        test_reset();
        test_write_read();
        test_back_to_back();
        test_backpressure();
        test_addr_err();
        test_reset_mid();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
